// File: rtl/zion_load_rsp_align_pkg.sv
// zion_load_pkg: access-size enum, per-request metadata struct and lane width helper
package zion_load_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef struct packed {
    logic [5:0] offset;
    size_e      size;
    logic       sgn;
  } meta_t;
  function automatic logic [9:0] lane_bits(size_e s);
    return 10'd8 << s;
  endfunction
endpackage

// File: rtl/zion_load_rsp_align_if.sv
// zion_load_rsp_align_if: request, memory, response and result handshakes; slave = aligner, master = environment
interface zion_load_rsp_align_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 64
);
  logic                  iReqVld, oReqRdy, iReqSigned;
  logic [ADDR_WIDTH-1:0] iReqAddr, oMemAddr;
  logic [1:0]            iReqSize;
  logic                  oMemVld, iMemRdy;
  logic                  iRspVld, oRspRdy;
  logic [DATA_WIDTH-1:0] iRspDat;
  logic                  oVld, iRdy, oErr;
  logic [OUT_WIDTH-1:0]  oDat;
  modport slave (
    input  iReqVld, iReqAddr, iReqSize, iReqSigned, iMemRdy, iRspVld, iRspDat, iRdy,
    output oReqRdy, oMemVld, oMemAddr, oRspRdy, oVld, oDat, oErr
  );
  modport master (
    output iReqVld, iReqAddr, iReqSize, iReqSigned, iMemRdy, iRspVld, iRspDat, iRdy,
    input  oReqRdy, oMemVld, oMemAddr, oRspRdy, oVld, oDat, oErr
  );
endinterface

// File: rtl/zion_load_rsp_align_meta_fifo.sv
// zion_load_meta_fifo: in-order metadata FIFO (push_i/din_i in, pop_i/dout_o out, full_o/empty_o/count_o status)
module zion_load_meta_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d  = wr_q + AW'(push_i);
    rd_d  = rd_q + AW'(pop_i);
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/zion_load_rsp_align.sv
// zion_load_rsp_align: tracks outstanding loads and aligns/extends returned words (clk, rst, bus slave modport)
module zion_load_rsp_align
  import zion_load_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 64,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic rst,
  zion_load_rsp_align_if.slave bus
);
  localparam int OFFB = $clog2(DATA_WIDTH / 8);
  logic full, empty, push, pop, rsp_acc;
  logic [$clog2(DEPTH):0] count;
  logic [$bits(meta_t)-1:0] head_raw;
  meta_t meta_in, head;
  logic [5:0] aoff;
  logic [OUT_WIDTH-1:0] raw, mask, top, res, dat_q, dat_d;
  logic vld_q, vld_d, err_q, err_d;
  assign bus.oMemVld  = bus.iReqVld & ~full;
  assign bus.oReqRdy  = bus.iMemRdy & ~full;
  assign bus.oMemAddr = {bus.iReqAddr[ADDR_WIDTH-1:OFFB], OFFB'(0)};
  assign push    = bus.iReqVld & bus.iMemRdy & ~full;
  assign bus.oRspRdy = ~vld_q | bus.iRdy;
  assign rsp_acc = bus.iRspVld & bus.oRspRdy;
  assign pop     = rsp_acc & ~empty;
  assign meta_in = '{offset: 6'(bus.iReqAddr[OFFB-1:0]), size: size_e'(bus.iReqSize), sgn: bus.iReqSigned};
  zion_load_meta_fifo #(.WIDTH($bits(meta_t)), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .din_i(meta_in),
    .dout_o(head_raw), .full_o(full), .empty_o(empty), .count_o(count)
  );
  assign head = meta_t'(head_raw);
  // Lane base bit = (offset aligned down to the lane size) * 8; mask's top bit is the lane sign bit
  always_comb begin
    aoff  = (head.offset >> head.size) << head.size;
    raw   = OUT_WIDTH'(bus.iRspDat >> {aoff, 3'b000});
    mask  = ~({OUT_WIDTH{1'b1}} << lane_bits(head.size));
    top   = mask & ~(mask >> 1);
    res   = (raw & mask) | ((head.sgn && |(raw & top)) ? ~mask : '0);
    vld_d = pop ? 1'b1 : (bus.iRdy ? 1'b0 : vld_q);
    dat_d = pop ? res : dat_q;
    err_d = rsp_acc & empty;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  assign bus.oVld = vld_q;
  assign bus.oDat = dat_q;
  assign bus.oErr = err_q;
  a_size_legal: assert property (@(posedge clk) disable iff (rst)
    push |-> int'(lane_bits(size_e'(bus.iReqSize))) <= OUT_WIDTH);
endmodule
